// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, Booth op-codes
// and a constant-function clog2 used to size the iteration counter.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Radix-2 recoding of the bit pair {Q[0], Q_1}.
  function automatic booth_op_t booth_op(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth iteration, purely combinational: add/sub of M into A, then a 1-bit
// arithmetic right shift of {A,Q,Q_1}. Zero latency, no flow control of its own.
module booth_step
  import booth_pkg::*;
#(
  parameter int MCAND_W  = 8,
  parameter int MPLIER_W = 4
) (
  input  logic [MCAND_W:0]    a,
  input  logic [MPLIER_W-1:0] q,
  input  logic                q_1,
  input  logic [MCAND_W:0]    mreg,
  output logic [MCAND_W:0]    a_nxt,
  output logic [MPLIER_W-1:0] q_nxt,
  output logic                q_1_nxt
);

  logic [MCAND_W:0] sum;
  booth_op_t        op;

  always_comb begin
    op  = booth_op(q[0], q_1);
    sum = a;
    case (op)
      OP_ADD:  sum = a + mreg;
      OP_SUB:  sum = a - mreg;
      default: sum = a;
    endcase
    // A carries one guard bit, so its MSB is always the true sign here.
    a_nxt   = {sum[MCAND_W], sum[MCAND_W:1]};
    q_nxt   = {sum[0], q[MPLIER_W-1:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier; MPLIER_W CALC cycles (data-dependent 1..MPLIER_W with BOOTH_EARLY_TERM_EN).
// One operation in flight: in_ready drops while busy, product held until out_ready.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int MCAND_W  = 8,
  parameter int MPLIER_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MCAND_W-1:0]            multiplicand,
  input  logic [MPLIER_W-1:0]           multiplier,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MCAND_W+MPLIER_W-1:0]   product,
  output logic                          busy
);

  localparam int PROD_W = MCAND_W + MPLIER_W;
  localparam int AW     = MCAND_W + 1;
  localparam int SW     = AW + MPLIER_W + 1;
  localparam int CNT_W  = clog2(MPLIER_W + 1);

  state_t              state;
  logic [AW-1:0]       a;
  logic [AW-1:0]       mreg;
  logic [MPLIER_W-1:0] q;
  logic                q_1;
  logic [CNT_W-1:0]    count;

  logic [AW-1:0]       a_nxt;
  logic [MPLIER_W-1:0] q_nxt;
  logic                q_1_nxt;

  booth_step #(
    .MCAND_W  (MCAND_W),
    .MPLIER_W (MPLIER_W)
  ) u_step (
    .a       (a),
    .q       (q),
    .q_1     (q_1),
    .mreg    (mreg),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt)
  );

`ifdef BOOTH_EARLY_TERM_EN
  // When Q[count-1:0] all match Q_1, every remaining step is a NOP shift,
  // so collapse them into one arithmetic shift by count.
  logic          rest_uniform;
  logic [SW-1:0] shifted;

  always_comb begin
    rest_uniform = 1'b1;
    for (int i = 0; i < MPLIER_W; i++) begin
      if ((i < int'(count)) && (q[i] != q_1)) begin
        rest_uniform = 1'b0;
      end
    end
    shifted = $signed({a, q, q_1}) >>> count;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      a         <= '0;
      mreg      <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mreg     <= {multiplicand[MCAND_W-1], multiplicand};
            a        <= '0;
            q        <= multiplier;
            q_1      <= 1'b0;
            count    <= CNT_W'(MPLIER_W);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end

        CALC: begin
`ifdef BOOTH_EARLY_TERM_EN
          if (rest_uniform) begin
            {a, q, q_1} <= shifted;
            count       <= '0;
            product     <= shifted[PROD_W:1];
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
`else
          begin
`endif
            a     <= a_nxt;
            q     <= q_nxt;
            q_1   <= q_1_nxt;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              product   <= {a_nxt[MCAND_W-1:0], q_nxt};
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          // in_ready only rises after this edge, so no accept overlaps the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  hold_under_backpressure: assert property (
    @(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(product))
  );

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corners plus a random sweep
// against a plain signed-multiply model; early-termination cases under BOOTH_EARLY_TERM_EN.
module tb_booth_mult_seq;

  localparam int MW = 8;
  localparam int QW = 4;
  localparam int PW = MW + QW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] multiplicand;
  logic [QW-1:0] multiplier;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(
    .MCAND_W  (MW),
    .MPLIER_W (QW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  function automatic logic [PW-1:0] ref_prod(input logic [MW-1:0] m, input logic [QW-1:0] q);
    int pm;
    int pq;
    pm = int'($signed(m));
    pq = int'($signed(q));
    return PW'(pm * pq);
  endfunction

  // Cycles from accept to out_valid. With early termination, iteration k stops
  // the run once multiplier bits k..QW-1 all equal the bit below k (0 below bit 0).
  function automatic int exp_lat(input logic [QW-1:0] q);
`ifdef BOOTH_EARLY_TERM_EN
    logic [QW:0] ext;
    logic        uniform;
    ext = {q, 1'b0};
    for (int k = 0; k < QW; k++) begin
      uniform = 1'b1;
      for (int j = k; j < QW; j++) begin
        if (ext[j+1] != ext[k]) uniform = 1'b0;
      end
      if (uniform) return k + 1;
    end
    return QW;
`else
    return QW;
`endif
  endfunction

  task automatic run_op(input logic [MW-1:0] m, input logic [QW-1:0] q,
                        output int lat, output logic [PW-1:0] prod);
    multiplicand = m;
    multiplier   = q;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    prod = product;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (product !== '0) begin bad++; $display("FAIL reset_product: got %h want 000", product); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int            lat;
    logic [PW-1:0] prod;
    out_ready = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir_ready_before: got %b want 1", in_ready); end
    run_op(8'hFA, 4'hE, lat, prod);
    total++; if (prod !== 12'h00C) begin bad++; $display("FAIL dir_product: got %h want 00c", prod); end
    total++; if (lat != exp_lat(4'hE)) begin bad++; $display("FAIL dir_latency: got %0d want %0d", lat, exp_lat(4'hE)); end
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL dir_busy_done: got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    drain();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL dir_after_hs: got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_extremes();
    logic [MW-1:0] ms [3];
    logic [QW-1:0] qs [3];
    logic [PW-1:0] ps [3];
    int            lat;
    logic [PW-1:0] prod;
    ms[0] = 8'h80; qs[0] = 4'h8; ps[0] = 12'h400;
    ms[1] = 8'h7F; qs[1] = 4'h7; ps[1] = 12'h379;
    ms[2] = 8'h80; qs[2] = 4'h7; ps[2] = 12'hC80;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(ms[i], qs[i], lat, prod);
      total++; if (prod !== ps[i]) begin bad++; $display("FAIL extreme_%0d_product: got %h want %h", i, prod, ps[i]); end
      total++; if (lat != exp_lat(qs[i])) begin bad++; $display("FAIL extreme_%0d_latency: got %0d want %0d", i, lat, exp_lat(qs[i])); end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int            lat;
    logic [PW-1:0] prod;
    out_ready = 1'b0;
    run_op(8'h7F, 4'h7, lat, prod);
    total++; if (prod !== 12'h379) begin bad++; $display("FAIL bp_product: got %h want 379", prod); end
    for (int i = 0; i < 3; i++) begin
      in_valid     = 1'b1;
      multiplicand = MW'($urandom);
      multiplier   = QW'($urandom);
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || product !== 12'h379 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d: got ov=%b prod=%h ir=%b want 1/379/0", i, out_valid, product, in_ready);
      end
    end
    // in_valid stays high across the handshake edge and must not be taken.
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_release: got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_queue: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_op();
    int            lat;
    logic [PW-1:0] prod;
    out_ready = 1'b1;
    run_op(8'h07, 4'h3, lat, prod);
    total++; if (prod !== 12'h015) begin bad++; $display("FAIL rmid_pre_product: got %h want 015", prod); end
    drain();
    multiplicand = 8'hFA;
    multiplier   = 4'hE;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
      bad++; $display("FAIL rmid_state: got ir=%b ov=%b busy=%b prod=%h want 1/0/0/000", in_ready, out_valid, busy, product);
    end
    run_op(8'h03, 4'h3, lat, prod);
    total++; if (prod !== 12'h009) begin bad++; $display("FAIL rmid_fresh_product: got %h want 009", prod); end
    drain();
  endtask

`ifdef BOOTH_EARLY_TERM_EN
  task automatic test_early_term();
    int            lat;
    logic [PW-1:0] prod;
    out_ready = 1'b1;
    run_op(8'h05, 4'h0, lat, prod);
    total++; if (prod !== 12'h000 || lat != 1) begin bad++; $display("FAIL et_zero: got prod=%h lat=%0d want 000/1", prod, lat); end
    drain();
    run_op(8'h05, 4'hF, lat, prod);
    total++; if (prod !== 12'hFFB || lat != 2) begin bad++; $display("FAIL et_minus1: got prod=%h lat=%0d want ffb/2", prod, lat); end
    drain();
  endtask
`endif

  task automatic test_random();
    int            lat;
    int            hold;
    logic [PW-1:0] prod;
    logic [MW-1:0] m;
    logic [QW-1:0] q;
    for (int n = 0; n < 1000; n++) begin
      m    = MW'($urandom);
      q    = QW'($urandom);
      hold = int'($urandom_range(0, 2));
      out_ready = (hold == 0);
      run_op(m, q, lat, prod);
      total++; if (prod !== ref_prod(m, q)) begin bad++; $display("FAIL rand_product %h*%h: got %h want %h", m, q, prod, ref_prod(m, q)); end
      total++; if (lat != exp_lat(q)) begin bad++; $display("FAIL rand_latency %h*%h: got %0d want %0d", m, q, lat, exp_lat(q)); end
      repeat (hold) @(posedge clk);
      #1;
      if (hold > 0) begin
        total++; if (out_valid !== 1'b1 || product !== ref_prod(m, q)) begin
          bad++; $display("FAIL rand_hold %h*%h: got ov=%b prod=%h want 1/%h", m, q, out_valid, product, ref_prod(m, q));
        end
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] want;
    logic [QW-1:0] prev_q;
    logic          acc;
    int            accepts;
    int            results;
    int            cyc;
    int            last_acc;
    accepts  = 0;
    results  = 0;
    cyc      = 0;
    last_acc = -1;
    prev_q   = '0;
    out_ready    = 1'b1;
    multiplicand = MW'($urandom);
    multiplier   = QW'($urandom);
    in_valid     = 1'b1;
    while (results < 5 && cyc < 200) begin
      acc = in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        exp_q.push_back(ref_prod(multiplicand, multiplier));
        if (last_acc >= 0) begin
          total++; if (cyc - last_acc != exp_lat(prev_q) + 2) begin
            bad++; $display("FAIL b2b_interval: got %0d want %0d", cyc - last_acc, exp_lat(prev_q) + 2);
          end
        end
        last_acc = cyc;
        prev_q   = multiplier;
        accepts++;
        multiplicand = MW'($urandom);
        multiplier   = QW'($urandom);
        if (accepts == 5) in_valid = 1'b0;
      end
      if (out_valid) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++; if (product !== want) begin bad++; $display("FAIL b2b_product_%0d: got %h want %h", results, product, want); end
        results++;
      end
    end
    in_valid = 1'b0;
    total++; if (results != 5) begin bad++; $display("FAIL b2b_timeout: got %0d results want 5", results); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_extremes();
    test_backpressure();
    test_reset_mid_op();
`ifdef BOOTH_EARLY_TERM_EN
    test_early_term();
`endif
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
